// File: rtl/draw_rect_phys_ctl_if.sv
// rtl/draw_rect_phys_ctl_if.sv - mouse/frame inputs and rectangle position outputs
// master: mouse and frame source (drives frame_tick, mouse_left, mouse_x/y_position)
// slave:  physics controller (drives xpos, ypos, busy)
interface draw_rect_phys_ctl_if;
  logic        frame_tick;
  logic        mouse_left;
  logic [11:0] mouse_x_position;
  logic [11:0] mouse_y_position;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;

  modport master (
    output frame_tick, mouse_left, mouse_x_position, mouse_y_position,
    input  xpos, ypos, busy
  );

  modport slave (
    input  frame_tick, mouse_left, mouse_x_position, mouse_y_position,
    output xpos, ypos, busy
  );
endinterface

// File: rtl/draw_rect_phys_ctl.sv
// rtl/draw_rect_phys_ctl.sv - gravity/bounce physics controller for the mouse-driven rectangle
// clk, rst_n (sync, active-low); bus.slave: frame_tick, mouse_left, mouse_x/y_position in;
// xpos/ypos (rectangle top-left, registered) and busy (falling or rising) out.
module draw_rect_phys_ctl #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int RECT_W     = 48,
  parameter int RECT_H     = 64,
  parameter int FRAC       = 8,
  parameter int GRAVITY    = 256,
  parameter int VMAX       = 16384,
  parameter int DAMP_SHIFT = 1,
  parameter int VMIN       = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  draw_rect_phys_ctl_if.slave  bus
);

  localparam int PW = 12 + FRAC;  // fixed-point position/velocity width
  localparam int AW = PW + 1;     // one guard bit for all intermediate arithmetic

  localparam logic [AW-1:0] FLOOR_FX = AW'((SCREEN_H - RECT_H) << FRAC);
  localparam logic [11:0]   XMAX     = 12'(SCREEN_W - RECT_W);
  localparam logic [AW-1:0] GRAV_FX  = AW'(GRAVITY);
  localparam logic [AW-1:0] VMAX_FX  = AW'(VMAX);
  localparam logic [AW-1:0] VMIN_FX  = AW'(VMIN);

  typedef enum logic [1:0] {S_FOLLOW, S_FALL, S_RISE, S_REST} state_t;

  state_t        state_q, state_d;
  logic [11:0]   pos_x_q, pos_x_d;
  logic [PW-1:0] pos_y_q, pos_y_d;
  logic [PW-1:0] vel_q, vel_d;
  logic          btn_q;
  logic [11:0]   xpos_q, ypos_q;
  logic          busy_q;

  logic          click;
  logic [AW-1:0] mouse_y_fx;
  logic [AW-1:0] vel_acc, vel_fall, y_fall, vel_damp, vel_rise;

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;

    click      = bus.mouse_left & ~btn_q;
    mouse_y_fx = {1'b0, bus.mouse_y_position, FRAC'(0)};

    // Falling step: accelerate, saturate, then advance using the new velocity.
    vel_acc  = {1'b0, vel_q} + GRAV_FX;
    vel_fall = (vel_acc > VMAX_FX) ? VMAX_FX : vel_acc;
    y_fall   = {1'b0, pos_y_q} + vel_fall;
    vel_damp = vel_fall - (vel_fall >> DAMP_SHIFT);
    // Rising step: only meaningful when vel_q > GRAVITY, so this never wraps when used.
    vel_rise = {1'b0, vel_q} - GRAV_FX;

    case (state_q)
      S_FOLLOW: begin
        pos_x_d = (bus.mouse_x_position > XMAX) ? XMAX : bus.mouse_x_position;
        pos_y_d = (mouse_y_fx > FLOOR_FX) ? FLOOR_FX[PW-1:0] : mouse_y_fx[PW-1:0];
        vel_d   = '0;
        // A click that coincides with a tick only arms the drop; stepping starts next tick.
        if (click) state_d = S_FALL;
      end
      S_FALL: begin
        if (bus.frame_tick) begin
          if (y_fall >= FLOOR_FX) begin
            pos_y_d = FLOOR_FX[PW-1:0];
            if (vel_damp < VMIN_FX) begin
              vel_d   = '0;
              state_d = S_REST;
            end else begin
              vel_d   = vel_damp[PW-1:0];
              state_d = S_RISE;
            end
          end else begin
            pos_y_d = y_fall[PW-1:0];
            vel_d   = vel_fall[PW-1:0];
          end
        end
      end
      S_RISE: begin
        if (bus.frame_tick) begin
          if ({1'b0, vel_q} <= GRAV_FX) begin
            vel_d   = '0;
            state_d = S_FALL;
          end else if (vel_rise > {1'b0, pos_y_q}) begin
            // Would overshoot the top of the screen: pin to 0 and start falling.
            pos_y_d = '0;
            vel_d   = '0;
            state_d = S_FALL;
          end else begin
            pos_y_d = pos_y_q - vel_rise[PW-1:0];
            vel_d   = vel_rise[PW-1:0];
          end
        end
      end
      S_REST: begin
        if (click) state_d = S_FOLLOW;
      end
      default: state_d = S_FOLLOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FOLLOW;
      pos_x_q <= '0;
      pos_y_q <= '0;
      vel_q   <= '0;
      btn_q   <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
      btn_q   <= bus.mouse_left;
      // Outputs load from next-state values so they move on the same edge as the state.
      xpos_q  <= pos_x_d;
      ypos_q  <= pos_y_d[PW-1:FRAC];
      busy_q  <= (state_d == S_FALL) || (state_d == S_RISE);
    end
  end

  assign bus.xpos = xpos_q;
  assign bus.ypos = ypos_q;
  assign bus.busy = busy_q;

endmodule
